// File: rtl/mcpu_control_fsm.sv
// -----------------------------------------------------------------------------
// mcpu_control_fsm
// Multi-cycle control unit for the MCPU datapath. It decodes opcode/funct from
// the IR and sequences the datapath enables and mux selects. It also handles a
// ready/request memory handshake with a timeout, JAL/JR sequencing,
// illegal-opcode trapping and a one-cycle retire pulse.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   opcode, funct       : IR[31:26] and IR[5:0]
//   zero                : ALU zero flag
//   mem_ready           : memory completes the current request this cycle
//   mem_req/mem_we      : memory request and write strobe
//   mem_addr_sel        : memory address source, 0 = PC, 1 = ALU reg
//   pc_we/ir_we/a_we/b_we/reg_we : datapath register write enables
//   reg_dst/reg_src     : regfile write destination and data source selects
//   alu_src_a/alu_src_b/imm_zext/alu_op : ALU operand selects and command
//   pc_src              : PC next-value select
//   retired             : pulse on the final cycle of each instruction
//   illegal/mem_timeout : sticky error flags, cleared only by reset
//   state               : current state, for debug
// -----------------------------------------------------------------------------
module mcpu_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               pc_we,
    output logic               ir_we,
    output logic               a_we,
    output logic               b_we,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         reg_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               imm_zext,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               retired,
    output logic               illegal,
    output logic               mem_timeout,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3);

    // Counter value at which one more idle cycle reaches the timeout limit.
    localparam logic [CNT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam bit               TO_EN     = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             wait_state_s;
    logic             timeout_hit_s;

    // Next state out of DECODE; HALT marks an unsupported opcode/funct.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t ns;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: ns = S_EXEC_R;
                    FN_JR:                  ns = S_JR;
                    default:                ns = S_HALT;
                endcase
            end
            OP_ADDI, OP_XORI: ns = S_EXEC_I;
            OP_LW, OP_SW:     ns = S_MEM_ADDR;
            OP_BEQ, OP_BNE:   ns = S_BRANCH;
            OP_J, OP_JAL:     ns = S_JUMP;
            default:          ns = S_HALT;
        endcase
        return ns;
    endfunction

    assign wait_state_s  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready in the limit cycle counts as completion, so it masks the timeout.
    assign timeout_hit_s = TO_EN && wait_state_s && !mem_ready && (wait_q == WAIT_LAST);

    // Next-state, wait counter and sticky flag computation.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        if (wait_state_s && !mem_ready && !timeout_hit_s) begin
            // Saturate so a disabled timeout never wraps back to zero.
            wait_d = (wait_q == {CNT_W{1'b1}}) ? wait_q : wait_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_d = '0;
        end

        if (timeout_hit_s) begin
            state_d   = S_HALT;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                S_RESET:    state_d = S_FETCH;
                S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    state_d = decode_next(opcode, funct);
                    if (decode_next(opcode, funct) == S_HALT) begin
                        illegal_d = 1'b1;
                    end else begin
                        illegal_d = illegal_q;
                    end
                end
                S_EXEC_R,
                S_EXEC_I:   state_d = S_ALU_WB;
                S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
                S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
                S_ALU_WB,
                S_MEM_WB,
                S_BRANCH,
                S_JUMP,
                S_JR:       state_d = S_FETCH;
                S_HALT:     state_d = S_HALT;
                default:    state_d = S_HALT;
            endcase
        end
    end

    // State, wait counter and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // State-decoded datapath controls; memory-completing enables follow mem_ready.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        a_we         = 1'b0;
        b_we         = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 2'd0;
        reg_src      = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        imm_zext     = 1'b0;
        alu_op       = ALU_ADD;
        pc_src       = 2'd0;
        retired      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                a_we      = 1'b1;
                b_we      = 1'b1;
                alu_src_b = 2'd3;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                imm_zext  = (opcode == OP_XORI);
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                retired = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                reg_we  = 1'b1;
                reg_src = 2'd1;
                retired = 1'b1;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = 1'b1;
                retired      = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                retired   = 1'b1;
                pc_we     = (opcode == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                pc_we   = 1'b1;
                pc_src  = 2'd2;
                retired = 1'b1;
                // PC still holds PC+4 here, so it is the link value for JAL.
                if (opcode == OP_JAL) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    reg_src = 2'd2;
                end else begin
                    reg_we  = 1'b0;
                end
            end
            S_JR: begin
                pc_we   = 1'b1;
                pc_src  = 2'd3;
                retired = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
module tb_mcpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, mem_addr_sel, pc_we, ir_we, a_we, b_we, reg_we;
    logic [1:0] reg_dst, reg_src, alu_src_a, alu_src_b, pc_src;
    logic       imm_zext, retired, illegal, mem_timeout;
    logic [2:0] alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mcpu_control_fsm #(.MEM_TIMEOUT(16), .ALUOP_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we),
        .b_we(b_we), .reg_we(reg_we), .reg_dst(reg_dst), .reg_src(reg_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .alu_op(alu_op), .pc_src(pc_src), .retired(retired), .illegal(illegal),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    // Every control output except the sticky flags and the debug state.
    logic [22:0] all_outs;
    assign all_outs = {mem_req, mem_we, mem_addr_sel, pc_we, ir_we, a_we, b_we, reg_we,
                       reg_dst, reg_src, alu_src_a, alu_src_b, imm_zext, alu_op, pc_src, retired};

    // Final-cycle view: {mem_req, mem_we, pc_we, pc_src, reg_we, reg_dst, reg_src}.
    logic [9:0] fin_outs;
    assign fin_outs = {mem_req, mem_we, pc_we, pc_src, reg_we, reg_dst, reg_src};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         len;
        logic [19:0] sts;   // expected state per cycle, one nibble each, cycle 0 in [3:0]
        logic [2:0] alu;    // expected alu_op in the third cycle
        logic       zext;   // expected imm_zext in the third cycle
        logic [9:0] fin;    // expected fin_outs in the retire cycle
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int cyc, rd_req, we_cnt, waits, fetch_cnt;
    bit done;

    initial begin
        vecs[0]  = '{"add",   6'h00, 6'h20, 1'b0, 4, 20'h05321, 3'd0, 1'b0, 10'b0_0_0_00_1_01_00};
        vecs[1]  = '{"sub",   6'h00, 6'h22, 1'b0, 4, 20'h05321, 3'd1, 1'b0, 10'b0_0_0_00_1_01_00};
        vecs[2]  = '{"slt",   6'h00, 6'h2A, 1'b0, 4, 20'h05321, 3'd3, 1'b0, 10'b0_0_0_00_1_01_00};
        vecs[3]  = '{"addi",  6'h08, 6'h00, 1'b0, 4, 20'h05421, 3'd0, 1'b0, 10'b0_0_0_00_1_00_00};
        vecs[4]  = '{"xori",  6'h0E, 6'h00, 1'b0, 4, 20'h05421, 3'd2, 1'b1, 10'b0_0_0_00_1_00_00};
        vecs[5]  = '{"lw",    6'h23, 6'h00, 1'b0, 5, 20'h87621, 3'd0, 1'b0, 10'b0_0_0_00_1_00_01};
        vecs[6]  = '{"sw",    6'h2B, 6'h00, 1'b0, 4, 20'h09621, 3'd0, 1'b0, 10'b1_1_0_00_0_00_00};
        vecs[7]  = '{"beq_z1",6'h04, 6'h00, 1'b1, 3, 20'h00A21, 3'd1, 1'b0, 10'b0_0_1_01_0_00_00};
        vecs[8]  = '{"beq_z0",6'h04, 6'h00, 1'b0, 3, 20'h00A21, 3'd1, 1'b0, 10'b0_0_0_01_0_00_00};
        vecs[9]  = '{"bne_z1",6'h05, 6'h00, 1'b1, 3, 20'h00A21, 3'd1, 1'b0, 10'b0_0_0_01_0_00_00};
        vecs[10] = '{"bne_z0",6'h05, 6'h00, 1'b0, 3, 20'h00A21, 3'd1, 1'b0, 10'b0_0_1_01_0_00_00};
        vecs[11] = '{"j",     6'h02, 6'h00, 1'b0, 3, 20'h00B21, 3'd0, 1'b0, 10'b0_0_1_10_0_00_00};
        vecs[12] = '{"jal",   6'h03, 6'h00, 1'b0, 3, 20'h00B21, 3'd0, 1'b0, 10'b0_0_1_10_1_10_10};
        vecs[13] = '{"jr",    6'h00, 6'h08, 1'b0, 3, 20'h00C21, 3'd0, 1'b0, 10'b0_0_1_11_0_00_00};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(all_outs), 32'd0);
        chk("reset_flags", 32'({illegal, mem_timeout}), 32'd0);
        step();
        chk("first_fetch", 32'(state), 32'd1);

        // Table-driven instruction sweep with mem_ready held high
        for (int v = 0; v < 14; v++) begin
            opcode = vecs[v].op;
            funct  = vecs[v].fn;
            zero   = vecs[v].z;
            mem_ready = 1'b1;
            for (int i = 0; i < vecs[v].len; i++) begin
                #1;
                chk($sformatf("%s_state%0d", vecs[v].name, i), 32'(state), 32'(vecs[v].sts[4*i +: 4]));
                chk($sformatf("%s_retired%0d", vecs[v].name, i), 32'(retired),
                    32'(i == vecs[v].len - 1));
                if (i == 0)
                    chk($sformatf("%s_fetch_outs", vecs[v].name),
                        32'({mem_req, mem_addr_sel, ir_we, pc_we, alu_src_a, alu_src_b, alu_op}),
                        32'({1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 3'd0}));
                if (i == 1)
                    chk($sformatf("%s_decode_outs", vecs[v].name),
                        32'({a_we, b_we, alu_src_a, alu_src_b, alu_op, pc_we, reg_we}),
                        32'({1'b1, 1'b1, 2'd0, 2'd3, 3'd0, 1'b0, 1'b0}));
                if (i == 2)
                    chk($sformatf("%s_exec_alu", vecs[v].name), 32'({alu_op, imm_zext}),
                        32'({vecs[v].alu, vecs[v].zext}));
                if (i == vecs[v].len - 1)
                    chk($sformatf("%s_final_outs", vecs[v].name), 32'(fin_outs), 32'(vecs[v].fin));
                step();
            end
        end
        chk("sweep_back_to_fetch", 32'(state), 32'd1);

        // LW with three wait cycles in MEM_RD: 8 cycles, 4 request cycles there
        opcode = 6'h23; funct = 6'h00;
        cyc = 0; rd_req = 0; we_cnt = 0; waits = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (state == 4'd7 && waits < 3) begin
                mem_ready = 1'b0;
                waits++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            cyc++;
            if (state == 4'd7 && mem_req) rd_req++;
            if (reg_we) begin
                we_cnt++;
                chk("lw_wait_reg_src", 32'({state, reg_src}), 32'({4'd8, 2'd1}));
            end
            if (retired) done = 1'b1;
            step();
        end
        chk("lw_wait_done", 32'(done), 32'd1);
        chk("lw_wait_cycles", 32'(cyc), 32'd8);
        chk("lw_wait_mem_req", 32'(rd_req), 32'd4);
        chk("lw_wait_reg_we", 32'(we_cnt), 32'd1);
        chk("lw_wait_back_fetch", 32'(state), 32'd1);

        // Timeout in FETCH: 16 idle cycles then HALT with mem_timeout
        mem_ready = 1'b0;
        fetch_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (state != 4'd1) break;
            fetch_cnt++;
            step();
        end
        chk("timeout_fetch_cycles", 32'(fetch_cnt), 32'd16);
        chk("timeout_state", 32'(state), 32'd15);
        chk("timeout_flags", 32'({mem_timeout, illegal}), 32'({1'b1, 1'b0}));
        chk("timeout_halt_outs", 32'(all_outs), 32'd0);
        reset = 1'b1;
        #1;
        chk("timeout_reset_clears", 32'({state, mem_timeout}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("timeout_refetch", 32'(state), 32'd1);

        // mem_ready arriving in the 16th FETCH cycle completes normally
        opcode = 6'h00; funct = 6'h20;
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) step();
        #1;
        chk("edge_still_fetch", 32'(state), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("edge_ir_we", 32'(ir_we), 32'd1);
        step();
        chk("edge_decode", 32'({state, mem_timeout}), 32'({4'd2, 1'b0}));

        // Reset asserted mid-instruction aborts at once
        reset = 1'b1;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_outs", 32'(all_outs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Illegal opcode traps into HALT and stays quiet
        opcode = 6'h3F; funct = 6'h00;
        step();
        step();
        chk("illegal_state", 32'({state, illegal, mem_timeout}), 32'({4'd15, 1'b1, 1'b0}));
        for (int k = 0; k < 20; k++) begin
            #1;
            chk($sformatf("illegal_quiet%0d", k), 32'({state, all_outs}), 32'({4'd15, 23'd0}));
            step();
        end
        reset = 1'b1;
        #1;
        chk("illegal_reset_clears", 32'({state, illegal}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("illegal_refetch", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
